// File: rtl/clock_pkg.sv
// Shared field width, field limits and wrap helper for the time_counter clock core.
package clock_pkg;

   localparam int TIME_W   = 6;
   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;

   typedef struct packed {
      logic [TIME_W-1:0] hour;
      logic [TIME_W-1:0] min;
   } hm_t;

   // Modulo increment; anything at or beyond the limit folds back to zero.
   function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v, input int max);
      logic [TIME_W-1:0] max_v;
      max_v = TIME_W'(max);
      if (v >= max_v) begin
         return {TIME_W{1'b0}};
      end else begin
         return v + {{(TIME_W-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/time_counter_mod_counter.sv
// Modulo-(MAX+1) counter used for the seconds, minutes and hours fields.
module mod_counter
   import clock_pkg::*;
#(
   parameter int W   = TIME_W,
   parameter int MAX = SEC_MAX
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q,
   output logic         carry
);

   localparam logic [W-1:0] MAX_V = W'(MAX);
   localparam logic [W-1:0] ONE_V = W'(1);

   logic [W-1:0] q_r;
   logic         at_max_s;

   assign at_max_s = (q_r >= MAX_V);
   assign carry    = inc & (q_r == MAX_V);
   assign q        = q_r;

   // Field register: clear beats increment, increment wraps at MAX.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r <= {W{1'b0}};
      end else if (clr) begin
         q_r <= {W{1'b0}};
      end else if (inc) begin
         q_r <= at_max_s ? {W{1'b0}} : (q_r + ONE_V);
      end else begin
         q_r <= q_r;
      end
   end

endmodule

// File: rtl/time_counter.sv
// Digital-clock time base: 1 Hz prescaler, sec/min/hour fields and button set mode.
// Optional alarm compare is built when the ALARM_EN macro is defined.
module time_counter
   import clock_pkg::*;
#(
   parameter int TICK_DIV = 50000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              set_mode,
   input  logic              inc_min,
   input  logic              inc_hour,
   input  logic              clr_sec,
   output logic [TIME_W-1:0] sec,
   output logic [TIME_W-1:0] min,
   output logic [TIME_W-1:0] hour,
   output logic              sec_tick
`ifdef ALARM_EN
   ,
   input  logic [TIME_W-1:0] alarm_min,
   input  logic [TIME_W-1:0] alarm_hour,
   output logic              alarm
`endif
);

   localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
   localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

   logic [PS_W-1:0] ps_r;
   logic            counting_s;
   logic            tick_s;
   logic            sec_tick_r;
   logic            inc_min_q_r;
   logic            inc_hour_q_r;
   logic            min_rise_s;
   logic            hour_rise_s;
   logic            set_min_s;
   logic            set_hour_s;
   logic            sec_inc_s;
   logic            sec_clr_s;
   logic            min_inc_s;
   logic            hour_inc_s;
   logic            sec_carry_s;
   logic            min_carry_s;
   logic            hour_carry_unused;

   assign counting_s = run & ~set_mode;
   assign tick_s     = counting_s & (ps_r == PS_LAST);

   // Prescaler: free-runs only while counting, otherwise parked at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         ps_r <= {PS_W{1'b0}};
      end else if (!counting_s) begin
         ps_r <= {PS_W{1'b0}};
      end else if (ps_r == PS_LAST) begin
         ps_r <= {PS_W{1'b0}};
      end else begin
         ps_r <= ps_r + PS_ONE;
      end
   end

   // sec_tick lines up with the cycle in which the advanced time is visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         sec_tick_r <= 1'b0;
      end else begin
         sec_tick_r <= tick_s;
      end
   end

   assign sec_tick = sec_tick_r;

   // Edge detectors track the buttons in every mode so a held button never re-fires.
   always_ff @(posedge clk) begin
      if (rst) begin
         inc_min_q_r  <= 1'b0;
         inc_hour_q_r <= 1'b0;
      end else begin
         inc_min_q_r  <= inc_min;
         inc_hour_q_r <= inc_hour;
      end
   end

   assign min_rise_s  = inc_min & ~inc_min_q_r;
   assign hour_rise_s = inc_hour & ~inc_hour_q_r;
   assign set_min_s   = set_mode & min_rise_s;
   assign set_hour_s  = set_mode & hour_rise_s;

   // Carries only ripple on ticks; set-mode edits never carry into the next field.
   assign sec_inc_s  = tick_s;
   assign sec_clr_s  = set_mode & clr_sec;
   assign min_inc_s  = (tick_s & sec_carry_s) | set_min_s;
   assign hour_inc_s = (tick_s & min_carry_s) | set_hour_s;

   mod_counter #(.W(TIME_W), .MAX(SEC_MAX)) u_sec (
      .clk   (clk),
      .rst   (rst),
      .inc   (sec_inc_s),
      .clr   (sec_clr_s),
      .q     (sec),
      .carry (sec_carry_s)
   );

   mod_counter #(.W(TIME_W), .MAX(MIN_MAX)) u_min (
      .clk   (clk),
      .rst   (rst),
      .inc   (min_inc_s),
      .clr   (1'b0),
      .q     (min),
      .carry (min_carry_s)
   );

   mod_counter #(.W(TIME_W), .MAX(HOUR_MAX)) u_hour (
      .clk   (clk),
      .rst   (rst),
      .inc   (hour_inc_s),
      .clr   (1'b0),
      .q     (hour),
      .carry (hour_carry_unused)
   );

`ifdef ALARM_EN
   hm_t  next_hm_s;
   hm_t  alarm_hm_s;
   logic min_step_s;
   logic any_rise_s;
   logic alarm_hit_s;
   logic alarm_r;

   // The alarm compares against the time the current tick is about to produce.
   assign min_step_s  = tick_s & sec_carry_s;
   assign any_rise_s  = min_rise_s | hour_rise_s;
   assign next_hm_s   = {(hour_inc_s ? wrap_inc(hour, HOUR_MAX) : hour), wrap_inc(min, MIN_MAX)};
   assign alarm_hm_s  = {alarm_hour, alarm_min};
   assign alarm_hit_s = min_step_s & (next_hm_s == alarm_hm_s);

   // Alarm latch: a button press silences it, otherwise the next minute change does.
   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_r <= 1'b0;
      end else if (any_rise_s) begin
         alarm_r <= 1'b0;
      end else if (alarm_hit_s) begin
         alarm_r <= 1'b1;
      end else if (min_step_s) begin
         alarm_r <= 1'b0;
      end else begin
         alarm_r <= alarm_r;
      end
   end

   assign alarm = alarm_r;
`endif

endmodule
